// File: rtl/count_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : count_window_ctrl
// Description : Sequences one counting window for a ones-counter bank.
//               A window is requested with START while idle. The bank is
//               cleared for one cycle, then enabled on every valid stream bit
//               until LENGTH valid bits have been counted. A final one-cycle
//               CAPTURE marks the counter values as final. ABORT ends a
//               window early without DONE.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   CLK      in   1      clock, all state changes on the rising edge
//   RST      in   1      synchronous active-high reset
//   START    in   1      request a window (honoured only while idle)
//   ABORT    in   1      terminate the current window without DONE
//   LENGTH   in   LEN_W  number of valid bits to count, latched at start
//   SN_VALID in   1      stream bit valid this cycle
//   CNT_EN   out  1      counter bank enable
//   CNT_WE   out  1      counter bank load strobe
//   CNT_DIN  out  LEN_W  counter bank load value (always zero)
//   BUSY     out  1      window in progress (clear, run or finish)
//   DONE     out  1      sticky flag: last window completed normally
//   CAPTURE  out  1      one-cycle pulse: counter values final
//   REMAIN   out  LEN_W  valid bits still to be counted
//   CYCLES   out  LEN_W  cycles spent counting, stalls included
// ============================================================================
module count_window_ctrl #(
    parameter int LEN_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             ABORT,
    input  logic [LEN_W-1:0] LENGTH,
    input  logic             SN_VALID,
    output logic             CNT_EN,
    output logic             CNT_WE,
    output logic [LEN_W-1:0] CNT_DIN,
    output logic             BUSY,
    output logic             DONE,
    output logic             CAPTURE,
    output logic [LEN_W-1:0] REMAIN,
    output logic [LEN_W-1:0] CYCLES
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_CLEAR  = 2'd1;
    localparam logic [1:0] c_RUN    = 2'd2;
    localparam logic [1:0] c_FINISH = 2'd3;

    localparam logic [LEN_W-1:0] c_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] c_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [LEN_W-1:0] r_remain;
    logic [LEN_W-1:0] r_cycles;
    logic             r_done;

    logic [1:0]       w_state_nxt;
    logic [LEN_W-1:0] w_remain_nxt;
    logic [LEN_W-1:0] w_cycles_nxt;
    logic             w_done_nxt;
    logic             w_cnt_en;
    logic             w_cnt_we;
    logic             w_capture;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= c_IDLE;
            r_remain <= c_ZERO;
            r_cycles <= c_ZERO;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_remain <= w_remain_nxt;
            r_cycles <= w_cycles_nxt;
            r_done   <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_remain_nxt = r_remain;
        w_cycles_nxt = r_cycles;
        w_done_nxt   = r_done;
        w_cnt_en     = 1'b0;
        w_cnt_we     = 1'b0;
        w_capture    = 1'b0;

        case (r_state)
            c_IDLE: begin
                // A simultaneous ABORT cancels the request before it starts.
                if (START && !ABORT) begin
                    w_state_nxt  = c_CLEAR;
                    w_remain_nxt = LENGTH;
                    w_cycles_nxt = c_ZERO;
                    w_done_nxt   = 1'b0;
                end
            end

            c_CLEAR: begin
                w_cnt_we = 1'b1;
                if (ABORT) begin
                    w_state_nxt = c_IDLE;
                end else if (r_remain == c_ZERO) begin
                    // Zero-length window skips counting entirely.
                    w_state_nxt = c_FINISH;
                end else begin
                    w_state_nxt = c_RUN;
                end
            end

            c_RUN: begin
                if (ABORT) begin
                    // Counters and status freeze where they are.
                    w_state_nxt = c_IDLE;
                end else begin
                    w_cnt_en     = SN_VALID;
                    w_cycles_nxt = r_cycles + c_ONE;
                    if (SN_VALID) begin
                        w_remain_nxt = r_remain - c_ONE;
                        if (r_remain == c_ONE) begin
                            w_state_nxt = c_FINISH;
                        end
                    end
                end
            end

            c_FINISH: begin
                // ABORT is deliberately ignored here: the count is complete.
                w_capture   = 1'b1;
                w_done_nxt  = 1'b1;
                w_state_nxt = c_IDLE;
            end

            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    assign CNT_EN  = w_cnt_en;
    assign CNT_WE  = w_cnt_we;
    assign CNT_DIN = c_ZERO;
    assign CAPTURE = w_capture;
    assign BUSY    = (r_state != c_IDLE);
    assign DONE    = r_done;
    assign REMAIN  = r_remain;
    assign CYCLES  = r_cycles;

endmodule
`default_nettype wire

// File: tb/tb_count_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_count_window_ctrl
// Description : Scoreboard bench for count_window_ctrl. Each window request
//               is turned into an expected transaction (enable trace, final
//               status) by a window-level model; a monitor rebuilds the same
//               transaction from the DUT outputs and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_count_window_ctrl;

    localparam int LEN_W = 32;

    logic             clk;
    logic             rst;
    logic             start;
    logic             abort;
    logic [LEN_W-1:0] length;
    logic             sn_valid;
    logic             cnt_en;
    logic             cnt_we;
    logic [LEN_W-1:0] cnt_din;
    logic             busy;
    logic             done;
    logic             capture;
    logic [LEN_W-1:0] remain;
    logic [LEN_W-1:0] cycles;

    count_window_ctrl #(.LEN_W(LEN_W)) dut (
        .CLK      (clk),
        .RST      (rst),
        .START    (start),
        .ABORT    (abort),
        .LENGTH   (length),
        .SN_VALID (sn_valid),
        .CNT_EN   (cnt_en),
        .CNT_WE   (cnt_we),
        .CNT_DIN  (cnt_din),
        .BUSY     (busy),
        .DONE     (done),
        .CAPTURE  (capture),
        .REMAIN   (remain),
        .CYCLES   (cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int        len;
        bit [63:0] pat;         // SN_VALID value for each counting cycle
        int        abort_at;    // counting cycle carrying ABORT, -1 = none
        bit        abort_clear; // ABORT during the clear cycle
        int        reset_at;    // counting cycle carrying RST, -1 = none
        bit        noise;       // random START/ABORT while busy
    } txn_t;

    typedef struct {
        int        len;
        bit        done;
        bit        cap;
        int        cycles;
        int        remain;
        int        tlen;
        bit [63:0] trace;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Number of counting cycles needed to see len valid bits in pattern p.
    function automatic int nat_run(input int len, input bit [63:0] p);
        int c;
        c = 0;
        if (len == 0) return 0;
        for (int i = 0; i < 64; i++) begin
            c += int'(p[i]);
            if (c == len) return i + 1;
        end
        return 64;
    endfunction

    function automatic exp_t model(input txn_t t);
        exp_t e;
        int   n;
        int   ones;
        e.len = t.len; e.done = 0; e.cap = 0; e.cycles = 0;
        e.remain = 0; e.tlen = 0; e.trace = '0;
        n = nat_run(t.len, t.pat);
        if (t.abort_clear) begin
            e.remain = t.len;
        end else if (t.reset_at >= 0) begin
            // Enable follows the stream in the reset cycle; everything clears after.
            e.tlen = t.reset_at + 1;
            for (int i = 0; i <= t.reset_at; i++) e.trace[i] = t.pat[i];
        end else if (t.abort_at >= 0) begin
            ones = 0;
            for (int i = 0; i < t.abort_at; i++) begin
                e.trace[i] = t.pat[i];
                ones += int'(t.pat[i]);
            end
            e.tlen   = t.abort_at + 1;
            e.cycles = t.abort_at;
            e.remain = t.len - ones;
        end else begin
            for (int i = 0; i < n; i++) e.trace[i] = t.pat[i];
            e.tlen   = n;
            e.cycles = n;
            e.done   = 1;
            e.cap    = 1;
        end
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        start = 0;
        for (int i = 0; i < n; i++) begin
            abort    = 1'($urandom_range(0, 1));
            sn_valid = 1'($urandom_range(0, 1));
            length   = $urandom;
            step();
        end
        abort = 0;
    endtask

    task automatic run_window(input txn_t t);
        int n;
        bit stop;
        sb.push_back(model(t));
        n = nat_run(t.len, t.pat);
        start = 1; abort = 0; length = t.len; sn_valid = 1'($urandom_range(0, 1));
        step();
        // clear cycle; LENGTH changes to show it is no longer sampled
        length   = $urandom;
        start    = t.noise ? 1'($urandom_range(0, 1)) : 1'b0;
        sn_valid = 1'($urandom_range(0, 1));
        abort    = t.abort_clear;
        step();
        abort = 0;
        if (!t.abort_clear) begin
            stop = 0;
            for (int k = 0; k < n && !stop; k++) begin
                sn_valid = t.pat[k];
                abort    = (k == t.abort_at);
                rst      = (k == t.reset_at);
                start    = t.noise ? 1'($urandom_range(0, 1)) : 1'b0;
                step();
                stop = (k == t.abort_at) || (k == t.reset_at);
            end
            if (!stop) begin
                sn_valid = 1'($urandom_range(0, 1));
                abort    = t.noise ? 1'($urandom_range(0, 1)) : 1'b0;
                start    = t.noise ? 1'($urandom_range(0, 1)) : 1'b0;
                step();
            end
        end
        start = 0; abort = 0; rst = 0; sn_valid = 0;
    endtask

    function automatic txn_t mk(input int len, input bit [63:0] pat);
        txn_t t;
        t.len = len; t.pat = pat; t.abort_at = -1; t.abort_clear = 0;
        t.reset_at = -1; t.noise = 0;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        int   idx;
        int   ones;
        int   n;
        int   sel;
        bit   b;
        t = mk($urandom_range(0, 12), '0);
        idx = 0; ones = 0;
        while (ones < t.len) begin
            b = (idx >= 40) ? 1'b1 : ($urandom_range(0, 9) < 6);
            t.pat[idx] = b;
            ones += int'(b);
            idx++;
        end
        n = nat_run(t.len, t.pat);
        sel = $urandom_range(0, 9);
        t.noise = 1'($urandom_range(0, 1));
        if (sel < 2 && n > 0)       t.abort_at = $urandom_range(0, n - 1);
        else if (sel == 2)          t.abort_clear = 1;
        else if (sel == 3 && n > 0) t.reset_at = $urandom_range(0, n - 1);
        return t;
    endfunction

    // ------------------------------------------------------------------ monitor
    bit        in_win = 0;
    bit        cap_seen;
    int        tl;
    bit [63:0] tr;

    always @(negedge clk) begin
        exp_t e;
        chk("we_en_exclusive", {63'd0, cnt_we & cnt_en}, 64'd0);
        chk("din_zero", 64'(cnt_din), 64'd0);
        if (cnt_we) begin
            in_win = 1; cap_seen = 0; tl = 0; tr = '0;
            if (sb.size() == 0) begin
                chk("unexpected_window", 64'd1, 64'd0);
            end else begin
                chk("clear_remain", 64'(remain), 64'(sb[0].len));
                chk("clear_cycles", 64'(cycles), 64'd0);
                chk("clear_done",   64'(done),   64'd0);
            end
        end else if (in_win && busy) begin
            if (capture) cap_seen = 1;
            else if (tl < 64) begin
                tr[tl] = cnt_en;
                tl++;
            end
        end else if (in_win && !busy) begin
            in_win = 0;
            if (sb.size() == 0) begin
                chk("scoreboard_underflow", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("end_done",    64'(done),    64'(e.done));
                chk("end_capture", 64'(cap_seen), 64'(e.cap));
                chk("end_cycles",  64'(cycles),  64'(e.cycles));
                chk("end_remain",  64'(remain),  64'(e.remain));
                chk("en_tlen",     64'(tl),      64'(e.tlen));
                chk("en_trace",    tr,           e.trace);
            end
        end else if (capture) begin
            chk("stray_capture", 64'd1, 64'd0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // ----------------------------------------------------------------- stimulus
    initial begin
        txn_t t;
        rst = 1; start = 1; abort = 0; length = 32'd9; sn_valid = 1;
        step(); step();
        chk("rst_busy",    64'(busy),    64'd0);
        chk("rst_cnt_en",  64'(cnt_en),  64'd0);
        chk("rst_cnt_we",  64'(cnt_we),  64'd0);
        chk("rst_capture", 64'(capture), 64'd0);
        chk("rst_done",    64'(done),    64'd0);
        chk("rst_remain",  64'(remain),  64'd0);
        chk("rst_cycles",  64'(cycles),  64'd0);
        rst = 0; start = 0;
        idle(2);

        run_window(mk(5, 64'h1F));           // constant valid
        idle(1);
        run_window(mk(4, 64'b1011001));       // stalls between valid bits
        idle(2);
        run_window(mk(0, '0));                // zero-length window
        idle(1);
        t = mk(10, 64'h3FF); t.abort_at = 3; t.noise = 1;
        run_window(t);                        // abort after 3 bits, START ignored
        idle(1);
        t = mk(10, 64'h3FF); t.reset_at = 4;
        run_window(t);                        // reset with 6 bits remaining
        chk("midrst_busy",   64'(busy),   64'd0);
        chk("midrst_remain", 64'(remain), 64'd0);

        // START together with ABORT in idle must not open a window
        start = 1; abort = 1; length = 32'd3;
        step();
        chk("start_abort_busy",  64'(busy),   64'd0);
        chk("start_abort_we",    64'(cnt_we), 64'd0);
        start = 0; abort = 0;
        idle(1);

        run_window(mk(2, 64'h3));             // back-to-back windows
        run_window(mk(3, 64'h7));
        idle(2);

        for (int w = 0; w < 40; w++) begin
            run_window(rand_txn());
            idle($urandom_range(0, 3));
        end
        idle(3);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/count_window_ctrl.md
COUNT_WINDOW_CTRL -- requirements
Module: count_window_ctrl

Interface
REQ-001 Parameter LEN_W, default 32: width of LENGTH, REMAIN, CYCLES and CNT_DIN.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST  input  1  synchronous, active-high reset.
REQ-004 START  input  1  request a new counting window; sampled only in IDLE.
REQ-005 ABORT  input  1  terminate the current window without DONE.
REQ-006 LENGTH  input  LEN_W  number of valid stream bits to count; latched on accepted START.
REQ-007 SN_VALID  input  1  stream bit presented to counters is valid this cycle.
REQ-008 CNT_EN  output  1  enable to the ones-counter bank.
REQ-009 CNT_WE  output  1  load strobe to the counter bank.
REQ-010 CNT_DIN  output  LEN_W  load value to the counter bank; constant 0.
REQ-011 BUSY  output  1  high in CLEAR, RUN, FINISH.
REQ-012 DONE  output  1  sticky: window completed normally.
REQ-013 CAPTURE  output  1  one-cycle pulse: counter values are final this cycle.
REQ-014 REMAIN  output  LEN_W  valid bits still to be counted.
REQ-015 CYCLES  output  LEN_W  clock cycles spent in RUN for the current/last window, stalls included.

Function
REQ-016 States: IDLE, CLEAR, RUN, FINISH; encoding is free.
REQ-017 IDLE, START=1, ABORT=0: latch REMAIN<=LENGTH, CYCLES<=0, DONE<=0, next state CLEAR.
REQ-018 IDLE, START=0 or ABORT=1: remain in IDLE; REMAIN, CYCLES, DONE unchanged.
REQ-019 CLEAR lasts exactly one cycle: CNT_WE=1, CNT_EN=0.
REQ-020 CLEAR -> RUN if REMAIN!=0; CLEAR -> FINISH if REMAIN==0 (zero-length window).
REQ-021 RUN: CNT_EN = SN_VALID & ~ABORT, combinational, same cycle; CNT_WE=0.
REQ-022 RUN: CYCLES increments by 1 every cycle; no wrap handling (modulo 2^LEN_W).
REQ-023 RUN, SN_VALID=1, ABORT=0: REMAIN decrements by 1.
REQ-024 RUN, SN_VALID=1, REMAIN==1, ABORT=0: next state FINISH, so exactly LENGTH CNT_EN cycles occur per window.
REQ-025 RUN, SN_VALID=0: REMAIN and state hold (stall).
REQ-026 FINISH lasts one cycle: CAPTURE=1, CNT_EN=0, CNT_WE=0; next state IDLE with DONE<=1.
REQ-027 ABORT=1 in CLEAR or RUN: next state IDLE, DONE stays 0, CNT_EN=0 that cycle, REMAIN and CYCLES freeze.
REQ-028 ABORT in FINISH is ignored; window completes with DONE=1.
REQ-029 START while BUSY is ignored; no restart, no latch of LENGTH.
REQ-030 CNT_WE and CNT_EN never both high in the same cycle.
REQ-031 CAPTURE high only in FINISH; CNT_WE high only in CLEAR.
REQ-032 START accepted back-to-back from IDLE the cycle after FINISH; DONE clears on that acceptance.

Reset
REQ-033 RST=1 at a clock edge: state IDLE, REMAIN=0, CYCLES=0, DONE=0, outputs CNT_EN=0, CNT_WE=0, CAPTURE=0, BUSY=0, CNT_DIN=0.
REQ-034 RST has priority over START, ABORT and all state transitions, including mid-window; no CAPTURE follows.

Verification
REQ-035 LENGTH=5, START pulse, SN_VALID=1 constantly -> CNT_WE high 1 cycle, CNT_EN high exactly 5 cycles, CAPTURE next cycle, DONE=1, CYCLES=5, REMAIN=0.
REQ-036 LENGTH=4, SN_VALID pattern 1,0,0,1,1,0,1 -> CNT_EN mirrors SN_VALID for 4 ones, FINISH after 7th RUN cycle, CYCLES=7.
REQ-037 LENGTH=0, START -> CLEAR then FINISH, CNT_EN never high, CAPTURE 1 cycle, DONE=1, CYCLES=0.
REQ-038 LENGTH=10, ABORT after 3 valid bits -> IDLE next cycle, DONE=0, REMAIN=7, no CAPTURE; START during RUN ignored.
REQ-039 RST asserted mid-RUN with REMAIN=6 -> all outputs reset values next cycle; START with ABORT same cycle in IDLE -> stays IDLE.
REQ-040 Back-to-back windows LENGTH=2 then 3 with START the cycle after FINISH -> DONE drops at second acceptance, second window counts 3, CYCLES restarts from 0.
